// File: rtl/h_bdy_iss.sv
// h_bdy_iss: command issue stage of the body pipeline.
// Pulls one opcode plus the key/value/hash fields that opcode needs from the
// front-end field queues, and registers them as one command. The command is
// presented to the table engine over a valid/ready handshake. Commands in
// flight are limited by a credit counter that completions replenish.
// Optional statistics counters are compiled in with H_BDY_ISSUE_STATS_EN.

package h_pkg;
  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OPC_NOP    = 3'd0;
  localparam logic [OPCODE_W-1:0] OPC_GET    = 3'd1;
  localparam logic [OPCODE_W-1:0] OPC_PUT    = 3'd2;
  localparam logic [OPCODE_W-1:0] OPC_DEL    = 3'd3;
  localparam logic [OPCODE_W-1:0] OPC_INC    = 3'd4;
  localparam logic [OPCODE_W-1:0] OPC_SCAN   = 3'd5;
  localparam logic [OPCODE_W-1:0] OPC_FLUSH  = 3'd6;
  localparam logic [OPCODE_W-1:0] OPC_APPEND = 3'd7;

  // Front-end field decoder, returns {has_k, has_v, has_hash}.
  function automatic logic [2:0] decode_fields(input logic [OPCODE_W-1:0] opc);
    logic [2:0] f;
    f = 3'b000;
    case (opc)
      OPC_GET:    f = 3'b101;
      OPC_PUT:    f = 3'b111;
      OPC_DEL:    f = 3'b101;
      OPC_INC:    f = 3'b111;
      OPC_SCAN:   f = 3'b100;
      OPC_APPEND: f = 3'b010;
      default:    f = 3'b000;
    endcase
    return f;
  endfunction
endpackage

package cfg_pkg;
  localparam int K_W = 16;
  localparam int V_W = 32;
  localparam int H_W = 12;
endpackage

module h_bdy_iss #(
  parameter int CREDITS_N = 4,
  parameter int STAT_W    = 32
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          i_opc_empty,
  input  logic [h_pkg::OPCODE_W-1:0]    i_opc_dat,
  output logic                          o_opc_pop,
  input  logic                          i_k_empty,
  input  logic [cfg_pkg::K_W-1:0]       i_k_dat,
  output logic                          o_k_pop,
  input  logic                          i_v_empty,
  input  logic [cfg_pkg::V_W-1:0]       i_v_dat,
  output logic                          o_v_pop,
  input  logic                          i_h_empty,
  input  logic [cfg_pkg::H_W-1:0]       i_h_dat,
  output logic                          o_h_pop,
  output logic                          o_iss_vld,
  output logic [h_pkg::OPCODE_W-1:0]    o_iss_opcode,
  output logic [cfg_pkg::K_W-1:0]       o_iss_k,
  output logic [cfg_pkg::V_W-1:0]       o_iss_v,
  output logic [cfg_pkg::H_W-1:0]       o_iss_h,
  input  logic                          i_iss_rdy,
  input  logic                          i_cpl_vld,
  output logic [$clog2(CREDITS_N+1)-1:0] o_credits,
  output logic                          o_err_credit
`ifdef H_BDY_ISSUE_STATS_EN
  ,
  output logic [STAT_W-1:0]             o_stat_issued,
  output logic [STAT_W-1:0]             o_stat_stall
`endif
);

  localparam int CRED_W = $clog2(CREDITS_N + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS_N);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              has_k;
  logic              has_v;
  logic              has_h;
  logic              ready_to_load;
  logic              load;
  logic [CRED_W-1:0] credits_q;
  logic              err_q;

  // Decode the opcode head into the set of field queues it draws from.
  always_comb begin
    {has_k, has_v, has_h} = h_pkg::decode_fields(i_opc_dat);
  end

  // A command can be assembled when every needed head is present and a
  // credit is free; reset holds it off so nothing is popped while in reset.
  always_comb begin
    ready_to_load = !i_opc_empty
                    && (!has_k || !i_k_empty)
                    && (!has_v || !i_v_empty)
                    && (!has_h || !i_h_empty)
                    && (credits_q != '0)
                    && !arst;
  end

  // Next-state and load decision; ISSUE only reloads when the engine accepts.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    o_iss_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_to_load) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        o_iss_vld = 1'b1;
        if (i_iss_rdy) begin
          if (ready_to_load) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_opc_pop = load;
  assign o_k_pop   = load && has_k;
  assign o_v_pop   = load && has_v;
  assign o_h_pop   = load && has_h;

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the command on a load; fields the opcode does not use read as zero.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_iss_opcode <= '0;
      o_iss_k      <= '0;
      o_iss_v      <= '0;
      o_iss_h      <= '0;
    end else if (load) begin
      o_iss_opcode <= i_opc_dat;
      o_iss_k      <= has_k ? i_k_dat : '0;
      o_iss_v      <= has_v ? i_v_dat : '0;
      o_iss_h      <= has_h ? i_h_dat : '0;
    end
  end

  // Credit accounting: loads consume, completions return, excess returns flag an error.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      credits_q <= CRED_MAX;
      err_q     <= 1'b0;
    end else begin
      case ({load, i_cpl_vld})
        2'b10: credits_q <= credits_q - CRED_W'(1);
        2'b01: begin
          if (credits_q == CRED_MAX) begin
            err_q <= 1'b1;
          end else begin
            credits_q <= credits_q + CRED_W'(1);
          end
        end
        default: credits_q <= credits_q;
      endcase
    end
  end

  assign o_credits    = credits_q;
  assign o_err_credit = err_q;

`ifdef H_BDY_ISSUE_STATS_EN
  logic [STAT_W-1:0] stat_issued_q;
  logic [STAT_W-1:0] stat_stall_q;

  // Saturating counts of accepted and back-pressured issue cycles.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (o_iss_vld && i_iss_rdy && !(&stat_issued_q)) begin
        stat_issued_q <= stat_issued_q + STAT_W'(1);
      end
      if (o_iss_vld && !i_iss_rdy && !(&stat_stall_q)) begin
        stat_stall_q <= stat_stall_q + STAT_W'(1);
      end
    end
  end

  assign o_stat_issued = stat_issued_q;
  assign o_stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_h_bdy_iss.sv
// tb_h_bdy_iss: directed and randomized bench for h_bdy_iss.
// The bench owns the four field queues, drives their heads, and predicts the
// issued command stream, pop pulses and credit count from a transaction-level
// model of the issue rules.

module tb_h_bdy_iss;

  localparam int N = 4;

  logic        clk;
  logic        arst;
  logic        i_opc_empty;
  logic [2:0]  i_opc_dat;
  logic        o_opc_pop;
  logic        i_k_empty;
  logic [15:0] i_k_dat;
  logic        o_k_pop;
  logic        i_v_empty;
  logic [31:0] i_v_dat;
  logic        o_v_pop;
  logic        i_h_empty;
  logic [11:0] i_h_dat;
  logic        o_h_pop;
  logic        o_iss_vld;
  logic [2:0]  o_iss_opcode;
  logic [15:0] o_iss_k;
  logic [31:0] o_iss_v;
  logic [11:0] o_iss_h;
  logic        i_iss_rdy;
  logic        i_cpl_vld;
  logic [2:0]  o_credits;
  logic        o_err_credit;
`ifdef H_BDY_ISSUE_STATS_EN
  logic [31:0] o_stat_issued;
  logic [31:0] o_stat_stall;
`endif

  h_bdy_iss #(.CREDITS_N(N), .STAT_W(32)) dut (
    .clk          (clk),
    .arst         (arst),
    .i_opc_empty  (i_opc_empty),
    .i_opc_dat    (i_opc_dat),
    .o_opc_pop    (o_opc_pop),
    .i_k_empty    (i_k_empty),
    .i_k_dat      (i_k_dat),
    .o_k_pop      (o_k_pop),
    .i_v_empty    (i_v_empty),
    .i_v_dat      (i_v_dat),
    .o_v_pop      (o_v_pop),
    .i_h_empty    (i_h_empty),
    .i_h_dat      (i_h_dat),
    .o_h_pop      (o_h_pop),
    .o_iss_vld    (o_iss_vld),
    .o_iss_opcode (o_iss_opcode),
    .o_iss_k      (o_iss_k),
    .o_iss_v      (o_iss_v),
    .o_iss_h      (o_iss_h),
    .i_iss_rdy    (i_iss_rdy),
    .i_cpl_vld    (i_cpl_vld),
    .o_credits    (o_credits),
    .o_err_credit (o_err_credit)
`ifdef H_BDY_ISSUE_STATS_EN
    ,
    .o_stat_issued(o_stat_issued),
    .o_stat_stall (o_stat_stall)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Bench-owned field queues (registered-output FIFOs as seen by the DUT).
  logic [2:0]  opc_q[$];
  logic [15:0] k_q[$];
  logic [31:0] v_q[$];
  logic [11:0] h_q[$];

  // Reference model state.
  logic [62:0] exp_q[$];
  int          m_credits;
  bit          m_err;
  bit          m_pending;
  int          m_issued;
  int          m_stall;

  // Which fields each opcode carries, as {key, value, hash}.
  function automatic logic [2:0] needs(input logic [2:0] opc);
    case (opc)
      3'd1:    return 3'b101;
      3'd2:    return 3'b111;
      3'd3:    return 3'b101;
      3'd4:    return 3'b111;
      3'd5:    return 3'b100;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveHeads();
    i_opc_empty = (opc_q.size() == 0);
    i_k_empty   = (k_q.size() == 0);
    i_v_empty   = (v_q.size() == 0);
    i_h_empty   = (h_q.size() == 0);
    i_opc_dat   = i_opc_empty ? 3'($urandom)  : opc_q[0];
    i_k_dat     = i_k_empty   ? 16'($urandom) : k_q[0];
    i_v_dat     = i_v_empty   ? $urandom      : v_q[0];
    i_h_dat     = i_h_empty   ? 12'($urandom) : h_q[0];
  endtask

  task automatic pushCmd(input logic [2:0] opc, input bit skip_v);
    logic [2:0] nd;
    nd = needs(opc);
    opc_q.push_back(opc);
    if (nd[2]) k_q.push_back(16'($urandom));
    if (nd[1] && !skip_v) v_q.push_back($urandom);
    if (nd[0]) h_q.push_back(12'($urandom));
    driveHeads();
  endtask

  task automatic modelReset();
    exp_q.delete();
    m_credits = N;
    m_err     = 1'b0;
    m_pending = 1'b0;
    m_issued  = 0;
    m_stall   = 0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_vld"}, 64'(o_iss_vld), 64'd0);
    checkOutput({tag, "_pops"}, 64'({o_opc_pop, o_k_pop, o_v_pop, o_h_pop}), 64'd0);
    checkOutput({tag, "_fields"}, 64'({o_iss_opcode, o_iss_k, o_iss_v, o_iss_h}), 64'd0);
    checkOutput({tag, "_credits"}, 64'(o_credits), 64'(N));
    checkOutput({tag, "_err"}, 64'(o_err_credit), 64'd0);
`ifdef H_BDY_ISSUE_STATS_EN
    checkOutput({tag, "_stat_issued"}, 64'(o_stat_issued), 64'd0);
    checkOutput({tag, "_stat_stall"}, 64'(o_stat_stall), 64'd0);
`endif
  endtask

  // One clock: compare at the falling edge, then advance model and queues.
  task automatic tick();
    logic [2:0]  nd;
    logic [62:0] cmd;
    bit          heads_ok;
    bit          ld;
    bit          acc;
    @(negedge clk);
    nd = (opc_q.size() > 0) ? needs(opc_q[0]) : 3'b000;
    heads_ok = (opc_q.size() > 0)
               && (!nd[2] || k_q.size() > 0)
               && (!nd[1] || v_q.size() > 0)
               && (!nd[0] || h_q.size() > 0);
    ld  = heads_ok && (m_credits > 0) && (!m_pending || i_iss_rdy);
    acc = m_pending && i_iss_rdy;
    checkOutput("pops", 64'({o_opc_pop, o_k_pop, o_v_pop, o_h_pop}),
                64'({ld, ld & nd[2], ld & nd[1], ld & nd[0]}));
    checkOutput("iss_vld", 64'(o_iss_vld), 64'(m_pending));
    if (m_pending && exp_q.size() > 0)
      checkOutput("cmd", 64'({o_iss_opcode, o_iss_k, o_iss_v, o_iss_h}), 64'(exp_q[0]));
    checkOutput("credits", 64'(o_credits), 64'(m_credits));
    checkOutput("err_credit", 64'(o_err_credit), 64'(m_err));
`ifdef H_BDY_ISSUE_STATS_EN
    checkOutput("stat_issued", 64'(o_stat_issued), 64'(m_issued));
    checkOutput("stat_stall", 64'(o_stat_stall), 64'(m_stall));
`endif
    @(posedge clk);
    #1;
    if (acc) begin
      void'(exp_q.pop_front());
      m_issued++;
    end else if (m_pending) begin
      m_stall++;
    end
    if (ld) begin
      cmd = {opc_q[0],
             nd[2] ? k_q[0] : 16'h0,
             nd[1] ? v_q[0] : 32'h0,
             nd[0] ? h_q[0] : 12'h0};
      exp_q.push_back(cmd);
      void'(opc_q.pop_front());
      if (nd[2]) void'(k_q.pop_front());
      if (nd[1]) void'(v_q.pop_front());
      if (nd[0]) void'(h_q.pop_front());
    end
    m_pending = ld ? 1'b1 : (acc ? 1'b0 : m_pending);
    if (ld && !i_cpl_vld) begin
      m_credits--;
    end else if (!ld && i_cpl_vld) begin
      if (m_credits == N) m_err = 1'b1;
      else m_credits++;
    end
    driveHeads();
  endtask

  task automatic applyStimulus(input bit rdy, input bit cpl, input int cycles);
    i_iss_rdy = rdy;
    i_cpl_vld = cpl;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic returnAll();
    i_cpl_vld = 1'b1;
    for (int i = 0; i < 16 && m_credits < N; i++) tick();
    i_cpl_vld = 1'b0;
  endtask

  initial begin
    arst      = 1'b1;
    i_iss_rdy = 1'b0;
    i_cpl_vld = 1'b0;
    modelReset();
    // A key+hash command is waiting during reset; a spare value must stay unpopped.
    v_q.push_back(32'hCAFE_0001);
    pushCmd(3'd1, 1'b0);
    #2;
    checkReset("reset");
    @(posedge clk);
    #1;
    checkReset("reset_hold");
    arst = 1'b0;

    $display("[TB] single key+hash command");
    applyStimulus(1'b1, 1'b0, 3);

    $display("[TB] back-to-back with credit exhaustion");
    returnAll();
    for (int i = 0; i < 5; i++) pushCmd(3'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("credits_drained", 64'(o_credits), 64'd0);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 3);
    returnAll();

    $display("[TB] backpressure");
    pushCmd(3'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 6);
    applyStimulus(1'b1, 1'b0, 2);

    $display("[TB] missing value field");
    pushCmd(3'd4, 1'b1);
    applyStimulus(1'b1, 1'b0, 3);
    v_q.push_back($urandom);
    driveHeads();
    applyStimulus(1'b1, 1'b0, 3);
    returnAll();

    $display("[TB] credit corner cases");
    pushCmd(3'd5, 1'b0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("credits_load_and_cpl", 64'(o_credits), 64'(N));
    applyStimulus(1'b1, 1'b1, 1);
    i_cpl_vld = 1'b0;
    checkOutput("err_set", 64'(o_err_credit), 64'd1);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("err_sticky", 64'(o_err_credit), 64'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) pushCmd(3'($urandom), 1'b0);
      i_iss_rdy = ($urandom_range(0, 3) != 0);
      i_cpl_vld = (m_credits < N) && ($urandom_range(0, 2) == 0);
      tick();
    end
    i_cpl_vld = 1'b0;
    returnAll();

    $display("[TB] reset while issuing under backpressure");
    pushCmd(3'd1, 1'b0);
    i_iss_rdy = 1'b0;
    for (int i = 0; i < 20 && !m_pending; i++) tick();
    checkOutput("pending_before_reset", 64'(o_iss_vld), 64'd1);
    arst = 1'b1;
    #1;
    modelReset();
    checkReset("mid_reset");
    @(posedge clk);
    #1;
    arst = 1'b0;
    driveHeads();
    pushCmd(3'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 4);
    returnAll();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
